uart_core: RTL

//  One full-duplex 8N1 UART channel: baud prescaler, TX shifter and 16x-oversampled RX with a FIFO in each direction.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_core_if.sv | 12 +
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_core.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_core channel: status bit positions, FSM states and
// oversampling constants.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_MID = 8;

  localparam int unsigned ST_RX_AVAIL     = 0;
  localparam int unsigned ST_RX_FULL      = 1;
  localparam int unsigned ST_RX_OVERRUN   = 2;
  localparam int unsigned ST_RX_FRAME_ERR = 3;
  localparam int unsigned ST_TX_FULL      = 4;
  localparam int unsigned ST_TX_IDLE      = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_core_if.sv
// CPU-side register strobes and read-back of one UART channel.
interface uart_core_if;
  logic [15:0] divider;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        rx_rd;
  logic [7:0]  rx_data;
  logic [5:0]  status;

  modport master (output divider, tx_data, tx_wr, rx_rd, input rx_data, status);
  modport slave  (input divider, tx_data, tx_wr, rx_rd, output rx_data, status);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; a write into a full FIFO is accepted only alongside a pop.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_wr, do_rd;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == (AW+1)'(DEPTH));
    dout     = empty ? '0 : mem_q[rd_ptr_q];
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr && !do_rd)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_wr && do_rd) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_core.sv
// One full-duplex 8N1 UART channel: baud prescaler, TX shifter and 16x-oversampled RX,
// each direction buffered by a uart_fifo.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  uart_core_if.slave  bus,
  input  logic        rxd,
  output logic        txd
);
  logic        rst_s1_q, rst_n;
  logic [15:0] pre_q, pre_d, div_eff;
  logic        tick;

  tx_state_e   tx_state_q, tx_state_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d, tx_head;
  logic        txd_q, txd_d, tx_pop, tx_last, tx_full, tx_empty;

  rx_state_e   rx_state_q, rx_state_d;
  logic [3:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall, rx_last, rx_push;
  logic        rx_ovr_q, rx_ovr_d, rx_fe_q, rx_fe_d, rx_full, rx_empty;
  logic [5:0]  st;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_s1_q <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_s1_q <= 1'b1;
      rst_n    <= rst_s1_q;
    end
  end

  uart_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(bus.tx_wr), .din(bus.tx_data),
    .rd_en(tx_pop), .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .wr_en(rx_push), .din(rx_sh_q),
    .rd_en(bus.rx_rd), .dout(bus.rx_data), .full(rx_full), .empty(rx_empty)
  );

  always_comb begin
    div_eff = (bus.divider == '0) ? 16'd1 : bus.divider;
    tick    = (pre_q == '0);
    pre_d   = tick ? div_eff - 16'd1 : pre_q - 16'd1;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    tx_last    = tick && (tx_cnt_q == 4'(OVERSAMPLE-1));
    if (tick && tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_q + 4'd1;
    unique case (tx_state_q)
      TX_IDLE: if (tick && !tx_empty) begin
        tx_pop = 1'b1; tx_sh_d = tx_head; txd_d = 1'b0; tx_cnt_d = '0; tx_state_d = TX_START;
      end
      TX_START: if (tx_last) begin
        txd_d = tx_sh_q[0]; tx_bit_d = '0; tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_last) begin
        if (tx_bit_q == 3'd7) begin
          txd_d = 1'b1; tx_state_d = TX_STOP;
        end else begin
          tx_sh_d = {1'b0, tx_sh_q[7:1]}; txd_d = tx_sh_q[1]; tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tx_last) begin
        // Chain straight into the next start bit so queued bytes leave with no gap.
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_head; txd_d = 1'b0; tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_fall    = rx_prev_q && !rx_s2_q;
    rx_last    = tick && (rx_cnt_q == 4'(OVERSAMPLE-1));
    if (tick && rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_q + 4'd1;
    unique case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_cnt_d = '0; rx_state_d = RX_START;
      end
      RX_START: if (tick && rx_cnt_q == 4'(SAMPLE_MID-1)) begin
        rx_cnt_d = '0; rx_bit_d = '0; rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_last) begin
        rx_sh_d = {rx_s2_q, rx_sh_q[7:1]}; rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_last) begin
        rx_push = 1'b1; rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    rx_ovr_d = bus.rx_rd ? 1'b0 : rx_ovr_q;
    rx_fe_d  = bus.rx_rd ? 1'b0 : rx_fe_q;
    if (rx_push && rx_full && !bus.rx_rd) rx_ovr_d = 1'b1;
    if (rx_push && !rx_s2_q)              rx_fe_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_ovr_q   <= 1'b0;
      rx_fe_q    <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_ovr_q   <= rx_ovr_d;
      rx_fe_q    <= rx_fe_d;
    end
  end

  always_comb begin
    st                  = '0;
    st[ST_RX_AVAIL]     = !rx_empty;
    st[ST_RX_FULL]      = rx_full;
    st[ST_RX_OVERRUN]   = rx_ovr_q;
    st[ST_RX_FRAME_ERR] = rx_fe_q;
    st[ST_TX_FULL]      = tx_full;
    st[ST_TX_IDLE]      = (tx_state_q == TX_IDLE) && tx_empty;
  end

  assign bus.status = st;
  assign txd        = txd_q;

endmodule
